// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-side drain stage for async_fifo (rd_clk domain).
// Issues fifo_rd_en, absorbs the FIFO's 1-cycle read latency with an
// in-flight flag, and presents the words as a valid/ready stream from a
// 2-entry skid buffer. Also counts delivered words and latches underflow.
//
// Stream handshake: a word transfers on every rising edge where
// out_valid && out_ready. Once out_valid is high, it and out_data hold
// steady until that transfer happens. out_valid never depends
// combinationally on out_ready.
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rstn,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  input  logic                  clr,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  underflow_sticky,
  output logic [1:0]            dbg_state,
  output logic                  dbg_in_flight
);

  // Buffer occupancy doubles as the FSM state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  in_flight_q;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;   // head (oldest word)
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;   // second entry
  logic [CNT_WIDTH-1:0]  rd_count_q;
  logic                  underflow_q;
  logic                  pop;
  logic [2:0]            level;

  assign out_valid        = (state_q != EMPTY);
  assign out_data         = buf0_q;
  assign pop              = out_valid & out_ready;
  assign rd_count         = rd_count_q;
  assign underflow_sticky = underflow_q;
  assign dbg_state        = state_q;
  assign dbg_in_flight    = in_flight_q;

  // Words already owned by this stage (buffered plus arriving this cycle).
  assign level = {1'b0, state_q} + {2'b00, in_flight_q};

  // Read only if, after this cycle's pop, there is room for one more word.
  // Written as level < 2 + pop so the comparison never goes negative.
  assign fifo_rd_en = rstn & ~fifo_empty & (level < (3'd2 + {2'b00, pop}));

  // Next occupancy and buffer contents from capture (in_flight) and pop.
  always_comb begin
    state_d = state_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    case (state_q)
      EMPTY: begin
        if (in_flight_q) begin
          buf0_d  = fifo_rd_data;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({in_flight_q, pop})
          2'b10: begin
            buf1_d  = fifo_rd_data;
            state_d = TWO;
          end
          2'b11:   buf0_d  = fifo_rd_data;
          2'b01:   state_d = EMPTY;
          default: state_d = ONE;
        endcase
      end
      TWO: begin
        // Capture without pop is excluded by the issue rule.
        if (pop) begin
          buf0_d = buf1_q;
          if (in_flight_q) buf1_d  = fifo_rd_data;
          else             state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, in-flight flag and buffer registers; reset drops any in-flight word.
  always_ff @(posedge rd_clk) begin
    if (!rstn) begin
      state_q     <= EMPTY;
      in_flight_q <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= fifo_rd_en;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

  // Delivered-word counter; clr beats a same-cycle pop, wraps naturally.
  always_ff @(posedge rd_clk) begin
    if (!rstn)     rd_count_q <= '0;
    else if (clr)  rd_count_q <= '0;
    else if (pop)  rd_count_q <= rd_count_q + 1'b1;
  end

  // Underflow latch; a new underflow beats a same-cycle clr.
  always_ff @(posedge rd_clk) begin
    if (!rstn)               underflow_q <= 1'b0;
    else if (fifo_underflow) underflow_q <= 1'b1;
    else if (clr)            underflow_q <= 1'b0;
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain: a behavioural 1-cycle-latency FIFO feeds
// the DUT; inputs change 1ns after the rising edge, checks happen 1ns after
// the falling edge. A second instance with a 4-bit counter shares all
// inputs so counter wrap-around is reachable in a few cycles.
module tb_fifo_rd_drain;

  localparam int DW = 8;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  logic          rstn = 1'b0;
  logic          fifo_underflow = 1'b0;
  logic          out_ready = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty;
  logic          fifo_rd_en, out_valid, underflow_sticky, dbg_in_flight;
  logic [DW-1:0] out_data;
  logic [CW-1:0] rd_count;
  logic [1:0]    dbg_state;

  logic          w_rd_en, w_valid, w_sticky, w_in_flight;
  logic [DW-1:0] w_data;
  logic [3:0]    w_count;
  logic [1:0]    w_state;

  fifo_rd_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rd_clk(rd_clk), .rstn(rstn), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_underflow(fifo_underflow),
    .fifo_rd_en(fifo_rd_en), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .clr(clr), .rd_count(rd_count),
    .underflow_sticky(underflow_sticky), .dbg_state(dbg_state),
    .dbg_in_flight(dbg_in_flight)
  );

  fifo_rd_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_w (
    .rd_clk(rd_clk), .rstn(rstn), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_underflow(fifo_underflow),
    .fifo_rd_en(w_rd_en), .out_valid(w_valid), .out_data(w_data),
    .out_ready(out_ready), .clr(clr), .rd_count(w_count),
    .underflow_sticky(w_sticky), .dbg_state(w_state),
    .dbg_in_flight(w_in_flight)
  );

  // ---------------- behavioural FIFO ----------------
  logic [DW-1:0] mem [0:255];
  int wp = 0;   // written only by driver tasks
  int rp = 0;   // written only by the read process
  assign fifo_empty = (wp == rp);

  always @(posedge rd_clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= mem[rp];
      rp <= rp + 1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [DW-1:0] got_q[$];      // every word transferred on the stream
  logic [DW-1:0] exp_q[$];      // words expected, in order
  logic rd_while_empty = 1'b0;
  logic overfill = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(negedge rd_clk) begin
    if (fifo_rd_en && fifo_empty) rd_while_empty = 1'b1;
    if (dbg_state == 2'd2 && dbg_in_flight && !(out_valid && out_ready)) overfill = 1'b1;
    if (out_valid && out_ready) got_q.push_back(out_data);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge rd_clk); #1;
  endtask

  task automatic mid();
    @(negedge rd_clk); #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[wp] = d;
    wp = wp + 1;
    exp_q.push_back(d);
  endtask

  // Runs until FIFO, in-flight slot and buffer are all empty (bounded).
  task automatic drain(input string name);
    int k;
    for (k = 0; k < 60; k++) begin
      mid();
      if (fifo_empty && !dbg_in_flight && !out_valid) break;
      tick();
    end
    n_checks++;
    if (k == 60) begin
      n_fail++;
      $display("FAIL %s drain timeout: got busy expected idle", name);
    end
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick();
    mid();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset out_data: got %h expected 00", out_data); end
    n_checks++; if (rd_count !== 16'h0000) begin n_fail++; $display("FAIL reset rd_count: got %h expected 0000", rd_count); end
    n_checks++; if (underflow_sticky !== 1'b0) begin n_fail++; $display("FAIL reset sticky: got %b expected 0", underflow_sticky); end
    n_checks++; if (dbg_state !== 2'd0 || dbg_in_flight !== 1'b0) begin n_fail++; $display("FAIL reset state: got %0d/%b expected 0/0", dbg_state, dbg_in_flight); end
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mid();
      n_checks++;
      if (fifo_rd_en !== 1'b0 || out_valid !== 1'b0 || rd_count !== 16'h0000) begin
        n_fail++;
        $display("FAIL idle cycle %0d: got rd_en=%b valid=%b cnt=%h expected 0/0/0000", i, fifo_rd_en, out_valid, rd_count);
      end
      tick();
    end
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 8; i++) push_word(8'(8'h11 + i));
    out_ready = 1'b1;
    // rd_en on cycles 0..7; data returns one cycle later and is captured at
    // the end of that cycle, so the stream is valid on cycles 2..9.
    for (int i = 0; i < 12; i++) begin
      mid();
      n_checks++;
      if (fifo_rd_en !== (i <= 7)) begin n_fail++; $display("FAIL stream rd_en cycle %0d: got %b expected %b", i, fifo_rd_en, (i <= 7)); end
      n_checks++;
      if (out_valid !== (i >= 2 && i <= 9)) begin n_fail++; $display("FAIL stream valid cycle %0d: got %b expected %b", i, out_valid, (i >= 2 && i <= 9)); end
      if (i >= 2 && i <= 9) begin
        exp_d = 8'(8'h11 + i - 2);
        n_checks++;
        if (out_data !== exp_d) begin n_fail++; $display("FAIL stream data cycle %0d: got %h expected %h", i, out_data, exp_d); end
      end
      tick();
    end
    mid();
    n_checks++; if (rd_count !== 16'd8) begin n_fail++; $display("FAIL stream rd_count: got %0d expected 8", rd_count); end
    tick();
  endtask

  task automatic test_stall();
    int base;
    int reads;
    base = got_q.size();
    reads = 0;
    for (int i = 0; i < 8; i++) push_word(8'(8'h21 + i));
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (fifo_rd_en) reads++;
      if (i >= 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h21) begin
          n_fail++;
          $display("FAIL stall hold cycle %0d: got valid=%b data=%h expected 1/21", i, out_valid, out_data);
        end
      end
      tick();
    end
    n_checks++; if (reads !== 2) begin n_fail++; $display("FAIL stall reads issued: got %0d expected 2", reads); end
    n_checks++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL stall occupancy: got %0d expected 2", dbg_state); end
    out_ready = 1'b1;
    drain("stall");
    n_checks++;
    if (got_q.size() - base !== 8) begin n_fail++; $display("FAIL stall word count: got %0d expected 8", got_q.size() - base); end
    for (int k = 0; k < 8 && base + k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[base + k] !== exp_q[base + k]) begin n_fail++; $display("FAIL stall order %0d: got %h expected %h", k, got_q[base + k], exp_q[base + k]); end
    end
    mid();
    n_checks++; if (rd_count !== 16'd16) begin n_fail++; $display("FAIL stall rd_count: got %0d expected 16", rd_count); end
    tick();
  endtask

  task automatic test_alternating();
    int base;
    base = got_q.size();
    for (int i = 0; i < 16; i++) push_word(8'(8'h40 + i));
    for (int i = 0; i < 80 && (got_q.size() - base) < 16; i++) begin
      out_ready = ~i[0];
      tick();
    end
    out_ready = 1'b1;
    drain("alternating");
    n_checks++;
    if (got_q.size() - base !== 16) begin n_fail++; $display("FAIL alt word count: got %0d expected 16", got_q.size() - base); end
    for (int k = 0; k < 16 && base + k < got_q.size(); k++) begin
      n_checks++;
      if (got_q[base + k] !== exp_q[base + k]) begin n_fail++; $display("FAIL alt order %0d: got %h expected %h", k, got_q[base + k], exp_q[base + k]); end
    end
    n_checks++; if (overfill !== 1'b0) begin n_fail++; $display("FAIL alt capture in TWO without pop: got %b expected 0", overfill); end
    n_checks++; if (rd_while_empty !== 1'b0) begin n_fail++; $display("FAIL alt rd_en while empty: got %b expected 0", rd_while_empty); end
    mid();
    n_checks++; if (rd_count !== 16'd32) begin n_fail++; $display("FAIL alt rd_count: got %0d expected 32", rd_count); end
    tick();
  endtask

  task automatic test_reset_mid();
    int base;
    // Reads are held off while rstn=0 even though the FIFO has data.
    push_word(8'h60);
    rstn = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mid();
      n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset gates rd_en cycle %0d: got %b expected 0", i, fifo_rd_en); end
      tick();
    end
    rstn = 1'b1;
    mid();
    n_checks++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL first read after reset: got %b expected 1", fifo_rd_en); end
    tick();
    drain("reset_pre");
    n_checks++; if (got_q[got_q.size() - 1] !== 8'h60) begin n_fail++; $display("FAIL reset_pre word: got %h expected 60", got_q[got_q.size() - 1]); end

    // Occupancy 2 with a read in flight is unreachable (the issue rule
    // stops reading at level 2), so reset hits occupancy 1 + in flight.
    base = got_q.size();
    out_ready = 1'b0;
    mem[wp] = 8'h61; mem[wp + 1] = 8'h62; wp = wp + 2;   // both discarded
    push_word(8'h63);
    push_word(8'h64);
    tick(); tick();
    rstn = 1'b0;
    mid();
    n_checks++; if (dbg_state !== 2'd1 || dbg_in_flight !== 1'b1) begin n_fail++; $display("FAIL reset_mid setup: got %0d/%b expected 1/1", dbg_state, dbg_in_flight); end
    tick();
    rstn = 1'b1;
    mid();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid out_valid: got %b expected 0", out_valid); end
    n_checks++; if (rd_count !== 16'h0000) begin n_fail++; $display("FAIL reset_mid rd_count: got %h expected 0000", rd_count); end
    n_checks++; if (dbg_in_flight !== 1'b0) begin n_fail++; $display("FAIL reset_mid in_flight: got %b expected 0", dbg_in_flight); end
    n_checks++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL reset_mid resume read: got %b expected 1", fifo_rd_en); end
    tick();
    out_ready = 1'b1;
    drain("reset_mid");
    n_checks++;
    if (got_q.size() - base !== 2) begin n_fail++; $display("FAIL reset_mid word count: got %0d expected 2", got_q.size() - base); end
    else begin
      n_checks++;
      if (got_q[base] !== 8'h63 || got_q[base + 1] !== 8'h64) begin
        n_fail++;
        $display("FAIL reset_mid resume words: got %h %h expected 63 64", got_q[base], got_q[base + 1]);
      end
    end
  endtask

  task automatic test_underflow_clr();
    mid();
    n_checks++; if (underflow_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky before pulse: got %b expected 0", underflow_sticky); end
    tick();
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) clr = 1'b1;   // takes effect at the end of this cycle
      mid();
      n_checks++; if (underflow_sticky !== 1'b1) begin n_fail++; $display("FAIL sticky held cycle %0d: got %b expected 1", i, underflow_sticky); end
      tick();
    end
    clr = 1'b0;
    mid();
    n_checks++; if (underflow_sticky !== 1'b0) begin n_fail++; $display("FAIL sticky after clr: got %b expected 0", underflow_sticky); end
    tick();
    clr = 1'b1;
    fifo_underflow = 1'b1;
    tick();
    clr = 1'b0;
    fifo_underflow = 1'b0;
    mid();
    n_checks++; if (underflow_sticky !== 1'b1) begin n_fail++; $display("FAIL sticky set beats clr: got %b expected 1", underflow_sticky); end
    tick();
  endtask

  task automatic test_count_wrap();
    int k;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mid();
    n_checks++; if (rd_count !== 16'd0 || w_count !== 4'd0) begin n_fail++; $display("FAIL wrap clr: got %h/%h expected 0000/0", rd_count, w_count); end
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) push_word(8'(8'h80 + i));
    drain("wrap15");
    mid();
    n_checks++; if (rd_count !== 16'd15 || w_count !== 4'hF) begin n_fail++; $display("FAIL wrap all-ones: got %h/%h expected 000f/f", rd_count, w_count); end
    tick();
    push_word(8'h8F);
    drain("wrap16");
    mid();
    n_checks++; if (rd_count !== 16'd16 || w_count !== 4'h0) begin n_fail++; $display("FAIL wrap to zero: got %h/%h expected 0010/0", rd_count, w_count); end
    tick();
    // clr in the same cycle as a pop: the counter must read zero.
    push_word(8'h90);
    for (k = 0; k < 10; k++) begin
      mid();
      if (out_valid) break;
      tick();
    end
    n_checks++;
    if (k == 10) begin n_fail++; $display("FAIL clr_pop wait timeout: got no valid expected valid"); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mid();
    n_checks++; if (rd_count !== 16'd0 || w_count !== 4'd0) begin n_fail++; $display("FAIL clr beats pop: got %h/%h expected 0000/0", rd_count, w_count); end
    n_checks++; if (got_q[got_q.size() - 1] !== 8'h90) begin n_fail++; $display("FAIL clr_pop word: got %h expected 90", got_q[got_q.size() - 1]); end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_alternating();
    test_reset_mid();
    test_underflow_clr();
    test_count_wrap();
    n_checks++; if (rd_while_empty !== 1'b0) begin n_fail++; $display("FAIL rd_en while empty overall: got %b expected 0", rd_while_empty); end
    n_checks++; if (overfill !== 1'b0) begin n_fail++; $display("FAIL capture in TWO overall: got %b expected 0", overfill); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
